// File: rtl/aes_input_loader_if.sv
// Upstream word stream into the AES input loader: one 32-bit word per
// in_valid && in_ready cycle, plus the key-reuse sideband.
interface aes_input_loader_if;
    // valid/ready: a word moves on every cycle where in_valid && in_ready.
    // The source holds in_valid, in_word and in_key_reuse steady until that
    // cycle and may not retract them. in_ready never depends on in_valid.
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_word;
    logic        in_key_reuse;

    modport master (
        output in_valid,
        output in_word,
        output in_key_reuse,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_word,
        input  in_key_reuse,
        output in_ready
    );
endinterface

// File: rtl/aes_input_loader.sv
// Collects four key words and four plaintext words, then runs the AES core and
// waits for completion or timeout. Key reuse is enabled by AES_LOADER_KEY_REUSE_EN.
module aes_input_loader #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                AES_clk,
    input  logic                AES_rst,
    aes_input_loader_if.slave   in_if,
    output logic                AES_en,
    output logic [127:0]        AES_data_in,
    output logic [127:0]        AES_key_in,
    input  logic                AES_data_out_valid,
    output logic                busy,
    output logic                timeout_err,
    output logic [2:0]          dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD_KEY  = 3'd1,
        S_LOAD_DATA = 3'd2,
        S_RUN       = 3'd3,
        S_REARM     = 3'd4
    } state_e;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_e       state_q;
    logic [1:0]   word_cnt_q;
    logic [7:0]   tmo_cnt_q;
    logic [127:0] key_q;
    logic [127:0] data_q;
    logic         en_q;
    logic         err_q;

    logic         in_ready_w;
    logic         accept;
    logic         last_word;
    logic         tmo_hit;
    logic         reuse_hit;

    // Held off during reset so no word can be taken on the edge that clears state.
    assign in_ready_w = ((state_q == S_IDLE) || (state_q == S_LOAD_KEY) ||
                         (state_q == S_LOAD_DATA)) && !AES_rst;
    assign accept     = in_if.in_valid && in_ready_w;
    assign last_word  = (word_cnt_q == 2'd3);
    assign tmo_hit    = (tmo_cnt_q == TMO_LAST);

`ifdef AES_LOADER_KEY_REUSE_EN
    logic key_valid_q;

    assign reuse_hit = in_if.in_key_reuse && key_valid_q;

    always_ff @(posedge AES_clk) begin
        if (AES_rst) begin
            key_valid_q <= 1'b0;
        end else if ((state_q == S_LOAD_KEY) && accept && last_word) begin
            key_valid_q <= 1'b1;
        end
    end
`else
    logic unused_key_reuse;

    assign unused_key_reuse = in_if.in_key_reuse;
    assign reuse_hit        = 1'b0;
`endif

    always_ff @(posedge AES_clk) begin
        if (AES_rst) begin
            state_q    <= S_IDLE;
            word_cnt_q <= 2'd0;
            tmo_cnt_q  <= 8'd0;
            key_q      <= 128'd0;
            data_q     <= 128'd0;
            en_q       <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        word_cnt_q <= 2'd1;
                        if (reuse_hit) begin
                            data_q  <= {data_q[95:0], in_if.in_word};
                            state_q <= S_LOAD_DATA;
                        end else begin
                            key_q   <= {key_q[95:0], in_if.in_word};
                            state_q <= S_LOAD_KEY;
                        end
                    end
                end
                S_LOAD_KEY: begin
                    if (accept) begin
                        key_q      <= {key_q[95:0], in_if.in_word};
                        word_cnt_q <= word_cnt_q + 2'd1;
                        if (last_word) begin
                            state_q <= S_LOAD_DATA;
                        end
                    end
                end
                S_LOAD_DATA: begin
                    // The 4th data word wraps the counter to 0 and starts the core.
                    if (accept) begin
                        data_q     <= {data_q[95:0], in_if.in_word};
                        word_cnt_q <= word_cnt_q + 2'd1;
                        if (last_word) begin
                            state_q   <= S_RUN;
                            en_q      <= 1'b1;
                            tmo_cnt_q <= 8'd0;
                        end
                    end
                end
                S_RUN: begin
                    // Completion takes priority over a timeout landing on the same cycle.
                    if (AES_data_out_valid) begin
                        state_q <= S_REARM;
                        en_q    <= 1'b0;
                    end else if (tmo_hit) begin
                        state_q <= S_REARM;
                        en_q    <= 1'b0;
                        err_q   <= 1'b1;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 8'd1;
                    end
                end
                S_REARM: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    en_q    <= 1'b0;
                end
            endcase
        end
    end

    assign in_if.in_ready = in_ready_w;
    assign AES_en         = en_q;
    assign AES_key_in     = key_q;
    assign AES_data_in    = data_q;
    assign timeout_err    = err_q;
    assign busy           = (state_q != S_IDLE);
    assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_aes_input_loader.sv
// Directed bench for aes_input_loader: a driver feeds word blocks, a monitor
// checks every RUN entry and exit against queued expectations.
module tb_aes_input_loader;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_LOAD_KEY  = 3'd1;
    localparam logic [2:0] ST_LOAD_DATA = 3'd2;
    localparam logic [2:0] ST_RUN       = 3'd3;
    localparam logic [2:0] ST_REARM     = 3'd4;

    localparam logic [127:0] K1 = 128'haa2bdb40_bff6a5e8_caa9ba3e_bc1e2acc;
    localparam logic [127:0] D1 = 128'h0000007a_00000000_00000000_00000000;
    localparam logic [127:0] K2 = 128'h00010203_04050607_08090a0b_0c0d0e0f;
    localparam logic [127:0] D2 = 128'h00112233_44556677_8899aabb_ccddeeff;
    localparam logic [127:0] K3 = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
    localparam logic [127:0] D3 = 128'h6bc1bee2_2e409f96_e93d7e11_7393172a;
    localparam logic [127:0] R4 = 128'ha6f2daeb_140fa720_529e75d5_21cbc681;

    logic         AES_clk;
    logic         AES_rst;
    logic         AES_en;
    logic [127:0] AES_data_in;
    logic [127:0] AES_key_in;
    logic         AES_data_out_valid;
    logic         busy;
    logic         timeout_err;
    logic [2:0]   dbg_state;

    aes_input_loader_if bus ();

    aes_input_loader #(.TIMEOUT_CYCLES(64)) dut (
        .AES_clk           (AES_clk),
        .AES_rst           (AES_rst),
        .in_if             (bus.slave),
        .AES_en            (AES_en),
        .AES_data_in       (AES_data_in),
        .AES_key_in        (AES_key_in),
        .AES_data_out_valid(AES_data_out_valid),
        .busy              (busy),
        .timeout_err       (timeout_err),
        .dbg_state_o       (dbg_state)
    );

    // Clock and watchdog
    initial begin
        AES_clk = 1'b0;
        forever #5 AES_clk = ~AES_clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Scoreboard
    logic [127:0] exp_key_q[$];
    logic [127:0] exp_data_q[$];
    logic [0:0]   exp_err_q[$];
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_block(input logic [127:0] k, input logic [127:0] d);
        exp_key_q.push_back(k);
        exp_data_q.push_back(d);
    endtask

    // Monitor: checks operands on every AES_en rise and the error flag on every fall.
    initial begin
        logic prev_en;
        prev_en = 1'b0;
        forever begin
            @(negedge AES_clk);
            if (AES_en && !prev_en) begin
                if (exp_key_q.size() == 0) begin
                    check("unexpected_run_entry", 128'(AES_en), 128'd0);
                end else begin
                    check("run_key", AES_key_in, exp_key_q.pop_front());
                    check("run_data", AES_data_in, exp_data_q.pop_front());
                end
            end else if (!AES_en && prev_en) begin
                if (exp_err_q.size() == 0) begin
                    check("unexpected_run_exit", 128'(AES_en), 128'd1);
                end else begin
                    check("exit_timeout_err", 128'(timeout_err), 128'(exp_err_q.pop_front()));
                end
            end
            prev_en = AES_en;
        end
    end

    // Driver tasks: inputs change #1 after the rising edge.
    task automatic send_word(input logic [31:0] w, input logic reuse);
        int n;
        n = 0;
        bus.in_valid     = 1'b1;
        bus.in_word      = w;
        bus.in_key_reuse = reuse;
        @(negedge AES_clk);
        while (!bus.in_ready && n < 200) begin
            @(negedge AES_clk);
            n++;
        end
        if (!bus.in_ready) check("send_word_wait", 128'(bus.in_ready), 128'd1);
        @(posedge AES_clk);
        #1;
    endtask

    task automatic send4(input logic [127:0] v, input logic reuse_first);
        logic [127:0] t;
        t = v;
        for (int i = 0; i < 4; i++) begin
            send_word(t[127:96], (i == 0) ? reuse_first : 1'b0);
            t = t << 32;
        end
    endtask

    task automatic idle_bus();
        bus.in_valid     = 1'b0;
        bus.in_key_reuse = 1'b0;
    endtask

    task automatic tick();
        @(posedge AES_clk);
        #1;
    endtask

    task automatic pulse_done();
        AES_data_out_valid = 1'b1;
        tick();
        AES_data_out_valid = 1'b0;
    endtask

    initial begin
        int n;
        logic [127:0] kp;
        AES_rst = 1'b1;
        AES_data_out_valid = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_word = 32'd0;
        bus.in_key_reuse = 1'b0;

        // Reset state
        repeat (3) @(posedge AES_clk);
        @(negedge AES_clk);
        check("ready_in_reset", 128'(bus.in_ready), 128'd0);
        @(posedge AES_clk);
        #1;
        AES_rst = 1'b0;
        @(negedge AES_clk);
        check("ready_after_reset", 128'(bus.in_ready), 128'd1);
        check("reset_en", 128'(AES_en), 128'd0);
        check("reset_busy", 128'(busy), 128'd0);
        check("reset_key", AES_key_in, 128'd0);
        check("reset_data", AES_data_in, 128'd0);
        check("reset_err", 128'(timeout_err), 128'd0);
        @(posedge AES_clk);
        #1;

        // Normal load, completion 12 cycles into RUN
        expect_block(K1, D1);
        exp_err_q.push_back(1'b0);
        send4(K1, 1'b0);
        send4(D1, 1'b0);
        idle_bus();
        check("en_after_word8", 128'(AES_en), 128'd1);
        check("state_run", 128'(dbg_state), 128'(ST_RUN));
        repeat (11) tick();
        pulse_done();
        check("done_en_low", 128'(AES_en), 128'd0);
        check("rearm_state", 128'(dbg_state), 128'(ST_REARM));
        check("rearm_ready", 128'(bus.in_ready), 128'd0);
        tick();
        check("idle_after_rearm", 128'(dbg_state), 128'(ST_IDLE));
        check("ready_after_rearm", 128'(bus.in_ready), 128'd1);

        // Completion flag outside RUN is ignored
        pulse_done();
        check("stray_done_state", 128'(dbg_state), 128'(ST_IDLE));
        check("stray_done_err", 128'(timeout_err), 128'd0);

        // Timeout with back-pressure during RUN
        expect_block(K2, D2);
        exp_err_q.push_back(1'b1);
        send4(K2, 1'b0);
        send4(D2, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_word = 32'hdeadbeef;
        bus.in_key_reuse = 1'b0;
        check("run_ready_low", 128'(bus.in_ready), 128'd0);
        n = 1;
        while (n < 300) begin
            tick();
            if (!AES_en) break;
            n++;
        end
        check("run_cycles", 128'(n), 128'd64);
        check("timeout_pulse", 128'(timeout_err), 128'd1);
        check("bp_key_hold", AES_key_in, K2);
        check("bp_data_hold", AES_data_in, D2);
        tick();
        check("timeout_pulse_end", 128'(timeout_err), 128'd0);
        check("rearm_no_capture", AES_key_in, K2);
        tick();
        idle_bus();
        kp = {K2[95:0], 32'hdeadbeef};
        check("held_word_taken", AES_key_in, kp);
        check("held_word_state", 128'(dbg_state), 128'(ST_LOAD_KEY));

        // Reset at word 6, then a fresh load ending on a completion/timeout tie
        send_word(32'h11111111, 1'b0);
        send_word(32'h22222222, 1'b0);
        send_word(32'h33333333, 1'b0);
        send_word(32'h44444444, 1'b0);
        send_word(32'h55555555, 1'b0);
        idle_bus();
        check("pre_reset_state", 128'(dbg_state), 128'(ST_LOAD_DATA));
        AES_rst = 1'b1;
        tick();
        AES_rst = 1'b0;
        check("mid_reset_key", AES_key_in, 128'd0);
        check("mid_reset_data", AES_data_in, 128'd0);
        check("mid_reset_state", 128'(dbg_state), 128'(ST_IDLE));
        check("mid_reset_en", 128'(AES_en), 128'd0);

        expect_block(K3, D3);
        exp_err_q.push_back(1'b0);
        send4(K3, 1'b1);
        send4(D3, 1'b0);
        idle_bus();
        repeat (63) tick();
        pulse_done();
        check("tie_en_low", 128'(AES_en), 128'd0);
        check("tie_no_err", 128'(timeout_err), 128'd0);
        check("tie_state", 128'(dbg_state), 128'(ST_REARM));
        tick();

        // Key-reuse stimulus
`ifdef AES_LOADER_KEY_REUSE_EN
        expect_block(K3, R4);
        exp_err_q.push_back(1'b0);
        send4(R4, 1'b1);
        idle_bus();
        check("reuse_run", 128'(dbg_state), 128'(ST_RUN));
`else
        expect_block(R4, 128'd0);
        exp_err_q.push_back(1'b0);
        send4(R4, 1'b1);
        idle_bus();
        check("noreuse_state", 128'(dbg_state), 128'(ST_LOAD_DATA));
        check("noreuse_key", AES_key_in, R4);
        send4(128'd0, 1'b0);
        idle_bus();
`endif
        check("final_run_en", 128'(AES_en), 128'd1);
        pulse_done();
        check("final_done", 128'(AES_en), 128'd0);
        repeat (3) tick();

        check("pending_blocks", 128'(exp_key_q.size()), 128'd0);
        check("pending_exits", 128'(exp_err_q.size()), 128'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
